// File: rtl/up_prog_loader.sv
// Program/debug loader for the up core: parses W/R/G/H byte commands from the UART
// receiver, drives program memory, answers through the UART transmitter, owns core_hold.
module up_prog_loader #(
    parameter int AW      = 8,
    parameter int DW      = 8,
    parameter int TIMEOUT = 100000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rx_valid,
    input  logic [7:0]    rx_data,
    input  logic          tx_busy,
    output logic          tx_start,
    output logic [7:0]    tx_data,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    output logic          mem_re,
    input  logic [DW-1:0] mem_rdata,
    output logic          core_hold,
    output logic          err
);
    localparam int AB = (AW + 7) / 8;
    localparam int WB = DW / 8;
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [7:0] CMD_W = 8'h57;
    localparam logic [7:0] CMD_R = 8'h52;
    localparam logic [7:0] CMD_G = 8'h47;
    localparam logic [7:0] CMD_H = 8'h48;
    localparam logic [7:0] ACK   = 8'h06;
    localparam logic [7:0] NAK   = 8'h15;

    typedef enum logic [3:0] {
        IDLE, ADDR, LEN, WDATA, WMEM, RREQ, RWAIT, RSEND, REPLY
    } state_t;

    state_t          state;
    logic            is_read;
    logic            discard;
    logic [1:0]      byte_cnt;
    logic [8*AB-1:0] addr_buf;
    logic [8:0]      words_left;
    logic [DW-1:0]   rbuf;
    logic [7:0]      sum;
    logic [7:0]      reply;
    logic [TW-1:0]   tcnt;

    logic tx_ok;
    logic timed_out;
    logic last_word;
    logic word_done;

    // A start is never issued back to back, giving tx_busy one cycle to rise.
    assign tx_ok     = !tx_busy && !tx_start;
    assign timed_out = (tcnt == TW'(TIMEOUT - 1));
    assign last_word = (words_left == 9'd1);
    assign word_done = (byte_cnt == 2'(WB - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            is_read    <= 1'b0;
            discard    <= 1'b0;
            byte_cnt   <= '0;
            addr_buf   <= '0;
            words_left <= '0;
            rbuf       <= '0;
            sum        <= '0;
            reply      <= '0;
            tcnt       <= '0;
            tx_start   <= 1'b0;
            tx_data    <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_we     <= 1'b0;
            mem_re     <= 1'b0;
            core_hold  <= 1'b1;
            err        <= 1'b0;
        end else begin
            // NOTE: strobes default low here so every branch below only has to raise them.
            tx_start <= 1'b0;
            mem_we   <= 1'b0;
            mem_re   <= 1'b0;
            err      <= 1'b0;

            // Tail of a rejected W/R packet: swallow bytes until the line goes quiet.
            if (discard) begin
                if (rx_valid) begin
                    tcnt <= '0;
                end else if (timed_out) begin
                    discard <= 1'b0;
                    tcnt    <= '0;
                end else begin
                    tcnt <= tcnt + TW'(1);
                end
            end

            if (state inside {ADDR, LEN, WDATA} && !rx_valid) begin
                if (timed_out) begin
                    err   <= 1'b1;
                    tcnt  <= '0;
                    state <= IDLE;
                end else begin
                    tcnt <= tcnt + TW'(1);
                end
            end

            if (rx_valid && !discard && state inside {RREQ, RWAIT, RSEND, REPLY})
                err <= 1'b1;

            case (state)
                IDLE: begin
                    if (rx_valid && !discard) begin
                        sum      <= '0;
                        byte_cnt <= '0;
                        tcnt     <= '0;
                        case (rx_data)
                            CMD_W, CMD_R: begin
                                if (core_hold) begin
                                    is_read <= (rx_data == CMD_R);
                                    state   <= ADDR;
                                end else begin
                                    err     <= 1'b1;
                                    reply   <= NAK;
                                    discard <= 1'b1;
                                    state   <= REPLY;
                                end
                            end
                            CMD_G: begin
                                core_hold <= 1'b0;
                                reply     <= ACK;
                                state     <= REPLY;
                            end
                            CMD_H: begin
                                core_hold <= 1'b1;
                                reply     <= ACK;
                                state     <= REPLY;
                            end
                            default: begin
                                err   <= 1'b1;
                                reply <= NAK;
                                state <= REPLY;
                            end
                        endcase
                    end
                end
                ADDR: begin
                    if (rx_valid) begin
                        tcnt                       <= '0;
                        addr_buf[8*byte_cnt +: 8] <= rx_data;
                        if (byte_cnt == 2'(AB - 1)) begin
                            byte_cnt <= '0;
                            state    <= LEN;
                        end else begin
                            byte_cnt <= byte_cnt + 2'd1;
                        end
                    end
                end
                LEN: begin
                    if (rx_valid) begin
                        tcnt       <= '0;
                        mem_addr   <= addr_buf[AW-1:0];
                        words_left <= (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
                        if (is_read) begin
                            mem_re <= 1'b1;
                            state  <= RREQ;
                        end else begin
                            state <= WDATA;
                        end
                    end
                end
                WDATA, WMEM: begin
                    // mem_we is high throughout WMEM; the address advances as it ends.
                    if (state == WMEM) begin
                        mem_addr   <= mem_addr + AW'(1);
                        words_left <= words_left - 9'd1;
                        if (last_word) begin
                            reply <= sum;
                            state <= REPLY;
                        end else begin
                            state <= WDATA;
                        end
                    end
                    if (rx_valid) begin
                        if (state == WMEM && last_word) begin
                            err <= 1'b1;
                        end else begin
                            tcnt                        <= '0;
                            sum                         <= sum + rx_data;
                            mem_wdata[8*byte_cnt +: 8] <= rx_data;
                            if (word_done) begin
                                byte_cnt <= '0;
                                mem_we   <= 1'b1;
                                state    <= WMEM;
                            end else begin
                                byte_cnt <= byte_cnt + 2'd1;
                            end
                        end
                    end
                end
                RREQ: begin
                    state <= RWAIT;
                end
                RWAIT: begin
                    rbuf     <= mem_rdata;
                    byte_cnt <= '0;
                    state    <= RSEND;
                end
                RSEND: begin
                    if (tx_ok) begin
                        tx_start <= 1'b1;
                        tx_data  <= rbuf[7:0];
                        rbuf     <= rbuf >> 8;
                        if (word_done) begin
                            byte_cnt   <= '0;
                            mem_addr   <= mem_addr + AW'(1);
                            words_left <= words_left - 9'd1;
                            if (last_word) begin
                                state <= IDLE;
                            end else begin
                                mem_re <= 1'b1;
                                state  <= RREQ;
                            end
                        end else begin
                            byte_cnt <= byte_cnt + 2'd1;
                        end
                    end
                end
                REPLY: begin
                    if (tx_ok) begin
                        tx_start <= 1'b1;
                        tx_data  <= reply;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_up_prog_loader.sv
// Directed bench for up_prog_loader (AW=8, DW=16, TIMEOUT=50): table of command
// packets with expected replies/writes, plus hand sequences for latency, timeout and reset.
module tb_up_prog_loader;
    localparam int AW = 8;
    localparam int DW = 16;
    localparam int TO = 50;

    logic          clk = 1'b0;
    logic          rst;
    logic          rx_valid;
    logic [7:0]    rx_data;
    logic          tx_busy;
    logic          tx_start;
    logic [7:0]    tx_data;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic          mem_re;
    logic [DW-1:0] mem_rdata;
    logic          core_hold;
    logic          err;

    up_prog_loader #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
        .mem_rdata(mem_rdata), .core_hold(core_hold), .err(err)
    );

    always #5 clk = ~clk;

    // Memory with one-cycle read latency and a UART transmitter busy for 4 cycles.
    logic [DW-1:0] mem [256] = '{default: '0};
    int busy_cnt = 0;
    assign tx_busy = (busy_cnt != 0);

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= mem[mem_addr];
        if (rst) busy_cnt <= 0;
        else if (tx_start) busy_cnt <= 4;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end

    logic [7:0]    txq[$];
    logic [AW-1:0] waq[$];
    logic [DW-1:0] wdq[$];
    int            err_cnt = 0;

    always @(negedge clk) begin
        if (tx_start) txq.push_back(tx_data);
        if (mem_we) begin
            waq.push_back(mem_addr);
            wdq.push_back(mem_wdata);
        end
        if (err) err_cnt++;
    end

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " tx_start"},  32'(tx_start),  32'h0);
        check({tag, " mem_we"},    32'(mem_we),    32'h0);
        check({tag, " mem_re"},    32'(mem_re),    32'h0);
        check({tag, " err"},       32'(err),       32'h0);
        check({tag, " tx_data"},   32'(tx_data),   32'h0);
        check({tag, " mem_addr"},  32'(mem_addr),  32'h0);
        check({tag, " mem_wdata"}, 32'(mem_wdata), 32'h0);
        check({tag, " core_hold"}, 32'(core_hold), 32'h1);
    endtask

    // rx and tx bytes are listed first-byte-leftmost in the packed fields.
    typedef struct {
        int          nb;
        logic [63:0] rx;
        int          ntx;
        logic [31:0] tx;
        int          nerr;
        logic        hold;
        int          nwr;
        logic [7:0]  wa0;
        logic [15:0] wd0;
        logic [7:0]  wa1;
        logic [15:0] wd1;
    } vec_t;

    task automatic run_vec(input string tag, input vec_t v);
        int tb0 = txq.size();
        int wb0 = waq.size();
        int eb0 = err_cnt;
        logic [7:0]  got8;
        logic [AW-1:0] gota;
        logic [DW-1:0] gotd;
        for (int i = 0; i < v.nb; i++) send_byte(v.rx[63-8*i -: 8], 12);
        repeat (80) @(negedge clk);
        check({tag, " tx_count"}, 32'(txq.size() - tb0), 32'(v.ntx));
        for (int i = 0; i < v.ntx; i++) begin
            got8 = (tb0 + i < txq.size()) ? txq[tb0 + i] : 8'hxx;
            check($sformatf("%s tx[%0d]", tag, i), 32'(got8), 32'(v.tx[31-8*i -: 8]));
        end
        check({tag, " err_count"}, 32'(err_cnt - eb0), 32'(v.nerr));
        check({tag, " core_hold"}, 32'(core_hold), 32'(v.hold));
        check({tag, " wr_count"}, 32'(waq.size() - wb0), 32'(v.nwr));
        for (int i = 0; i < v.nwr; i++) begin
            gota = (wb0 + i < waq.size()) ? waq[wb0 + i] : 'x;
            gotd = (wb0 + i < wdq.size()) ? wdq[wb0 + i] : 'x;
            check($sformatf("%s wr_addr[%0d]", tag, i), 32'(gota), 32'((i == 0) ? v.wa0 : v.wa1));
            check($sformatf("%s wr_data[%0d]", tag, i), 32'(gotd), 32'((i == 0) ? v.wd0 : v.wd1));
        end
    endtask

    vec_t vecs[9];
    vec_t post_reset;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int t0;
        int w0;
        vecs[0] = '{1, 64'h47_00_00_00_00_00_00_00, 1, 32'h06_00_00_00, 0, 1'b0, 0, 8'h00, 16'h0000, 8'h00, 16'h0000};
        vecs[1] = '{7, 64'h57_10_02_11_22_33_44_00, 1, 32'h15_00_00_00, 1, 1'b0, 0, 8'h00, 16'h0000, 8'h00, 16'h0000};
        vecs[2] = '{1, 64'h48_00_00_00_00_00_00_00, 1, 32'h06_00_00_00, 0, 1'b1, 0, 8'h00, 16'h0000, 8'h00, 16'h0000};
        vecs[3] = '{1, 64'h99_00_00_00_00_00_00_00, 1, 32'h15_00_00_00, 1, 1'b1, 0, 8'h00, 16'h0000, 8'h00, 16'h0000};
        vecs[4] = '{7, 64'h57_10_02_AA_BB_CC_DD_00, 1, 32'h0E_00_00_00, 0, 1'b1, 2, 8'h10, 16'hBBAA, 8'h11, 16'hDDCC};
        vecs[5] = '{7, 64'h57_FF_02_34_12_CD_AB_00, 1, 32'hBE_00_00_00, 0, 1'b1, 2, 8'hFF, 16'h1234, 8'h00, 16'hABCD};
        vecs[6] = '{3, 64'h52_FF_02_00_00_00_00_00, 4, 32'h34_12_CD_AB, 0, 1'b1, 0, 8'h00, 16'h0000, 8'h00, 16'h0000};
        vecs[7] = '{4, 64'h57_20_02_11_00_00_00_00, 0, 32'h00_00_00_00, 1, 1'b1, 0, 8'h00, 16'h0000, 8'h00, 16'h0000};
        vecs[8] = '{1, 64'h48_00_00_00_00_00_00_00, 1, 32'h06_00_00_00, 0, 1'b1, 0, 8'h00, 16'h0000, 8'h00, 16'h0000};
        post_reset = '{5, 64'h57_40_01_77_88_00_00_00, 1, 32'hFF_00_00_00, 0, 1'b1, 1, 8'h40, 16'h8877, 8'h00, 16'h0000};

        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 9; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

        // Write strobe follows the final byte of a word by exactly one cycle.
        t0 = txq.size();
        send_byte(8'h57, 12);
        send_byte(8'h30, 12);
        send_byte(8'h01, 12);
        send_byte(8'h55, 12);
        send_byte(8'h66, 0);
        check("lat mem_we", 32'(mem_we), 32'h1);
        check("lat mem_addr", 32'(mem_addr), 32'h30);
        check("lat mem_wdata", 32'(mem_wdata), 32'h6655);
        @(negedge clk);
        check("lat mem_we_drop", 32'(mem_we), 32'h0);
        repeat (40) @(negedge clk);
        check("lat reply", 32'((txq.size() > t0) ? txq[t0] : 8'hxx), 32'hBB);

        // Inter-byte timeout fires exactly TIMEOUT cycles after the last byte.
        w0 = waq.size();
        send_byte(8'h57, 12);
        send_byte(8'h20, 12);
        send_byte(8'h02, 12);
        send_byte(8'h11, 0);
        for (int k = 1; k <= TO; k++) begin
            @(negedge clk);
            if (k == TO - 1) check("to err_early", 32'(err), 32'h0);
            if (k == TO) check("to err_pulse", 32'(err), 32'h1);
        end
        repeat (20) @(negedge clk);
        check("to no_write", 32'(waq.size() - w0), 32'h0);

        // LEN = 0 reads 256 words starting at address 0.
        t0 = txq.size();
        send_byte(8'h52, 12);
        send_byte(8'h00, 12);
        send_byte(8'h00, 0);
        for (int c = 0; c < 6000; c++) begin
            if (txq.size() - t0 >= 512) break;
            @(negedge clk);
        end
        repeat (20) @(negedge clk);
        check("len0 count", 32'(txq.size() - t0), 32'd512);
        if (txq.size() - t0 >= 512) begin
            check("len0 byte0",   32'(txq[t0 + 0]),   32'hCD);
            check("len0 byte1",   32'(txq[t0 + 1]),   32'hAB);
            check("len0 byte32",  32'(txq[t0 + 32]),  32'hAA);
            check("len0 byte35",  32'(txq[t0 + 35]),  32'hDD);
            check("len0 byte97",  32'(txq[t0 + 97]),  32'h66);
            check("len0 byte510", 32'(txq[t0 + 510]), 32'h34);
            check("len0 byte511", 32'(txq[t0 + 511]), 32'h12);
        end

        // Reset in the middle of a word aborts the packet without a write.
        w0 = waq.size();
        send_byte(8'h57, 12);
        send_byte(8'h40, 12);
        send_byte(8'h01, 12);
        send_byte(8'h01, 3);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_outputs("midrst");
        rst = 1'b0;
        repeat (80) @(negedge clk);
        check("midrst no_write", 32'(waq.size() - w0), 32'h0);
        run_vec("post_reset", post_reset);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
